// File: rtl/sprite_bus_pkg.sv
// rtl/sprite_bus_pkg.sv - shared widths, command record and writer states for the sprite register bus
package sprite_bus_pkg;

   localparam int SPRITE_ADDR_W = 5;
   localparam int SPRITE_DATA_W = 32;
   localparam int NUM_SPRITES   = 20;

   typedef struct packed {
      logic [SPRITE_ADDR_W-1:0] index;
      logic [SPRITE_DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      WRITE = 2'd2
   } writer_state_t;

endpackage

// File: rtl/sprite_reg_writer_if.sv
// rtl/sprite_reg_writer_if.sv - command stream and Avalon-MM write port of the sprite register writer
interface sprite_reg_writer_if;
   import sprite_bus_pkg::*;

   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [SPRITE_ADDR_W-1:0] cmd_index;
   logic [SPRITE_DATA_W-1:0] cmd_data;

   logic [SPRITE_ADDR_W-1:0] avm_address;
   logic [SPRITE_DATA_W-1:0] avm_writedata;
   logic                     avm_write;
   logic                     avm_chipselect;
   logic                     avm_waitrequest;

   modport master (
      input  cmd_valid, cmd_index, cmd_data, avm_waitrequest,
      output cmd_ready, avm_address, avm_writedata, avm_write, avm_chipselect
   );

   modport slave (
      output cmd_valid, cmd_index, cmd_data, avm_waitrequest,
      input  cmd_ready, avm_address, avm_writedata, avm_write, avm_chipselect
   );

endinterface

// File: rtl/sprite_cmd_fifo.sv
// rtl/sprite_cmd_fifo.sv - synchronous command FIFO; extra pointer bit separates full from empty
module sprite_cmd_fifo
   import sprite_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  cmd_t push_cmd,
   input  logic pop,
   output logic full,
   output logic empty,
   output cmd_t head
);

   localparam int AW = $clog2(DEPTH);

   cmd_t        mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= push_cmd;
   end

endmodule

// File: rtl/sprite_reg_writer.sv
// rtl/sprite_reg_writer.sv - buffers sprite commands and writes them to the sprite register file, optionally only in vblank
module sprite_reg_writer #(
   parameter int DEPTH       = 4,
   parameter int NUM_SPRITES = sprite_bus_pkg::NUM_SPRITES,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 gate_en,
   input  logic                 vblank,
   input  logic                 err_clr,
   sprite_reg_writer_if.master  bus,
   output logic                 busy,
   output logic                 err_index,
   output logic [CNT_W-1:0]     writes_done
);
   import sprite_bus_pkg::*;

   // Assertion is immediate through the flops' async clear; release is seen two edges later.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rst_sync <= 2'b00;
      else
         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   writer_state_t state, state_nxt;

   logic fifo_full, fifo_empty;
   logic accept, idx_bad, push, pop, load;
   cmd_t head, in_cmd;

   logic [SPRITE_ADDR_W-1:0] addr_q;
   logic [SPRITE_DATA_W-1:0] data_q;

   assign bus.cmd_ready = !fifo_full;
   assign accept        = bus.cmd_valid && !fifo_full;
   assign idx_bad       = int'(bus.cmd_index) >= NUM_SPRITES;
   assign push          = accept && !idx_bad;
   assign in_cmd        = '{index: bus.cmd_index, data: bus.cmd_data};

   sprite_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_cmd (in_cmd),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Gate inputs matter only while ARMED; a started write always runs to completion.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = ARMED;
         ARMED:   if (!gate_en || vblank) begin
                     state_nxt = WRITE;
                     load      = 1'b1;
                  end
         WRITE:   if (!bus.avm_waitrequest) begin
                     state_nxt = IDLE;
                     pop       = 1'b1;
                  end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         data_q      <= '0;
         writes_done <= '0;
         err_index   <= 1'b0;
      end else begin
         if (load) begin
            addr_q <= head.index;
            data_q <= head.data;
         end
         if (pop)
            writes_done <= writes_done + CNT_W'(1);
         if (accept && idx_bad)
            err_index <= 1'b1;
         else if (err_clr)
            err_index <= 1'b0;
      end
   end

   assign bus.avm_write      = (state == WRITE);
   assign bus.avm_chipselect = (state == WRITE);
   assign bus.avm_address    = addr_q;
   assign bus.avm_writedata  = data_q;
   assign busy               = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_sprite_reg_writer.sv
// tb/tb_sprite_reg_writer.sv - directed and randomized checks of sprite_reg_writer against a queue model
module tb_sprite_reg_writer;

   localparam int NUM = 20;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        gate_en = 1'b0;
   logic        vblank  = 1'b0;
   logic        err_clr = 1'b0;
   logic        busy;
   logic        err_index;
   logic [15:0] writes_done;

   sprite_reg_writer_if bus();

   sprite_reg_writer #(.DEPTH(4), .NUM_SPRITES(NUM), .CNT_W(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .gate_en     (gate_en),
      .vblank      (vblank),
      .err_clr     (err_clr),
      .bus         (bus),
      .busy        (busy),
      .err_index   (err_index),
      .writes_done (writes_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: every in-range accepted command must appear as exactly one write, in order.
   logic [36:0] exp_q [$];
   int          exp_sent = 0;
   logic        exp_err  = 1'b0;
   logic        rand_bus = 1'b0;
   logic [36:0] mon_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (reset_n && bus.avm_write && !bus.avm_waitrequest) begin
         chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
         chk("write_cs", 32'(bus.avm_chipselect), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("write_addr", 32'(bus.avm_address), 32'(mon_e[36:32]));
            chk("write_data", bus.avm_writedata, mon_e[31:0]);
         end
      end
   end

   task automatic send(input logic [4:0] idx, input logic [31:0] data);
      int   n;
      logic acc;
      bus.cmd_valid = 1'b1;
      bus.cmd_index = idx;
      bus.cmd_data  = data;
      n = 0;
      do begin
         acc = bus.cmd_ready;
         step();
         n++;
         if (rand_bus) begin
            bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
            vblank              = 1'($urandom_range(0, 1));
         end
      end while (!acc && n < 200);
      bus.cmd_valid = 1'b0;
      chk("send_accepted", 32'(acc), 32'd1);
      if (acc) begin
         if (int'(idx) < NUM) begin
            exp_q.push_back({idx, data});
            exp_sent++;
         end else begin
            exp_err = 1'b1;
         end
      end
   endtask

   task automatic wait_write(input string tag);
      int n = 0;
      while (!bus.avm_write && n < 300) begin
         step();
         n++;
      end
      chk(tag, 32'(bus.avm_write), 32'd1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (busy && n < 1000) begin
         step();
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_count"}, 32'(writes_done), exp_sent);
      chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic        saw;

      bus.cmd_valid       = 1'b0;
      bus.cmd_index       = '0;
      bus.cmd_data        = '0;
      bus.avm_waitrequest = 1'b0;

      step();
      step();
      reset_n = 1'b1;
      step();
      step();
      step();

      chk("rst_write", 32'(bus.avm_write), 32'd0);
      chk("rst_cs", 32'(bus.avm_chipselect), 32'd0);
      chk("rst_addr", 32'(bus.avm_address), 32'd0);
      chk("rst_data", bus.avm_writedata, 32'd0);
      chk("rst_err", 32'(err_index), 32'd0);
      chk("rst_done", 32'(writes_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);

      // Single write: accepted in cycle 0, strobe in cycle 3 for one cycle.
      send(5'd3, 32'h00AB_1234);
      chk("single_c1_write", 32'(bus.avm_write), 32'd0);
      step();
      chk("single_c2_write", 32'(bus.avm_write), 32'd0);
      step();
      chk("single_c3_write", 32'(bus.avm_write), 32'd1);
      chk("single_c3_cs", 32'(bus.avm_chipselect), 32'd1);
      chk("single_c3_addr", 32'(bus.avm_address), 32'd3);
      chk("single_c3_data", bus.avm_writedata, 32'h00AB_1234);
      chk("single_c3_busy", 32'(busy), 32'd1);
      step();
      chk("single_c4_write", 32'(bus.avm_write), 32'd0);
      chk("single_c4_done", 32'(writes_done), 32'd1);
      chk("single_c4_busy", 32'(busy), 32'd0);

      // Backpressure: five stalled cycles, six cycles of stable strobe.
      bus.avm_waitrequest = 1'b1;
      d = $urandom;
      send(5'd7, d);
      wait_write("bp_strobe");
      for (int k = 0; k < 6; k++) begin
         chk("bp_hold_write", 32'(bus.avm_write), 32'd1);
         chk("bp_hold_addr", 32'(bus.avm_address), 32'd7);
         chk("bp_hold_data", bus.avm_writedata, d);
         if (k == 5) bus.avm_waitrequest = 1'b0;
         step();
      end
      chk("bp_done_write", 32'(bus.avm_write), 32'd0);
      chk("bp_done_count", 32'(writes_done), 32'd2);
      step();
      step();
      chk("bp_single_pop", 32'(writes_done), 32'd2);

      // FIFO full: four fill it while stalled, the fifth waits for the first pop.
      bus.avm_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) send(5'(i), $urandom);
      chk("full_ready", 32'(bus.cmd_ready), 32'd0);
      d = $urandom;
      bus.cmd_valid = 1'b1;
      bus.cmd_index = 5'd4;
      bus.cmd_data  = d;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("full_hold_ready", 32'(bus.cmd_ready), 32'd0);
      end
      bus.avm_waitrequest = 1'b0;
      send(5'd4, d);
      drain("full");

      // Out-of-range indices are consumed, never written, and raise a sticky flag.
      send(5'd25, $urandom);
      chk("bad_err_set", 32'(err_index), 32'd1);
      for (int i = 0; i < 5; i++) step();
      chk("bad_err_sticky", 32'(err_index), 32'd1);
      chk("bad_no_busy", 32'(busy), 32'd0);
      chk("bad_no_write", 32'(writes_done), exp_sent);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      exp_err = 1'b0;
      chk("bad_err_clr", 32'(err_index), 32'd0);
      err_clr = 1'b1;
      send(5'd25, $urandom);
      err_clr = 1'b0;
      chk("bad_set_wins", 32'(err_index), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      exp_err = 1'b0;
      send(5'd20, $urandom);
      chk("bound_20_err", 32'(err_index), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      exp_err = 1'b0;
      send(5'd19, $urandom);
      drain("bound_19");
      chk("bound_19_err", 32'(err_index), 32'd0);

      // Vblank gating, and a stalled write surviving vblank falling.
      gate_en = 1'b1;
      vblank  = 1'b0;
      send(5'd0, $urandom);
      saw = 1'b0;
      for (int i = 0; i < 100; i++) begin
         saw = saw | bus.avm_write;
         step();
      end
      chk("gate_no_strobe", 32'(saw), 32'd0);
      vblank = 1'b1;
      step();
      chk("gate_strobe", 32'(bus.avm_write), 32'd1);
      drain("gate");
      bus.avm_waitrequest = 1'b1;
      send(5'd5, $urandom);
      wait_write("gate_stall_strobe");
      vblank  = 1'b0;
      gate_en = 1'b0;
      step();
      gate_en = 1'b1;
      step();
      chk("gate_stall_held", 32'(bus.avm_write), 32'd1);
      bus.avm_waitrequest = 1'b0;
      drain("gate_stall");
      gate_en = 1'b0;

      // Randomized traffic with random stalls, gating and a mix of good and bad indices.
      rand_bus = 1'b1;
      gate_en  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(5'($urandom_range(0, 31)), $urandom);
         for (int j = $urandom_range(0, 3); j > 0; j--) begin
            bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
            vblank              = 1'($urandom_range(0, 1));
            step();
         end
      end
      rand_bus            = 1'b0;
      bus.avm_waitrequest = 1'b0;
      gate_en             = 1'b0;
      drain("rand");
      chk("rand_err", 32'(err_index), 32'(exp_err));

      // Asynchronous reset in the middle of a stalled write with three more queued.
      bus.avm_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) send(5'($urandom_range(0, NUM - 1)), $urandom);
      wait_write("arst_strobe");
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_write", 32'(bus.avm_write), 32'd0);
      chk("arst_cs", 32'(bus.avm_chipselect), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      exp_sent = 0;
      exp_err  = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
      step();
      step();
      chk("arst_rel_busy", 32'(busy), 32'd0);
      chk("arst_rel_done", 32'(writes_done), 32'd0);
      chk("arst_rel_ready", 32'(bus.cmd_ready), 32'd1);
      bus.avm_waitrequest = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         saw = saw | bus.avm_write;
         step();
      end
      chk("arst_no_stale", 32'(saw), 32'd0);
      send(5'd11, $urandom);
      drain("arst_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
